// File: rtl/vx_exe_issue_arb.sv
// vx_exe_issue_arb
//   Round-robin arbiter that lets NUM_REQS issue-slot dispatch requesters
//   share one execute-unit block input. One winner per cycle is pushed into
//   a 2-entry elastic buffer. The buffer's registered full flag gates
//   req_ready, so out_ready never reaches req_ready combinationally.
//   The head entry also carries the index of the slot that produced it,
//   which the commit path uses to route results back.
//
//   Optional feature macro: VX_EXE_ARB_PERF_EN
//     defined   -> perf_stalls / perf_conflicts are live 32-bit counters
//     undefined -> both outputs are tied to 0 and no counters are built
module vx_exe_issue_arb #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int SEL_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]               out_sel,
  input  logic                           out_ready,
  output logic [31:0]                    perf_stalls,
  output logic [31:0]                    perf_conflicts
);

  // The valid vector is zero-padded to a power of two. Any SEL_W-bit index
  // can then select from it safely, including for non-power-of-2 NUM_REQS.
  localparam int SCAN_W = 1 << SEL_W;

  // ------------------------------------------------------------------
  // Arbitration state and signals
  // ------------------------------------------------------------------
  logic [SEL_W-1:0]      ptr_reg;
  logic [SEL_W-1:0]      ptr_next;
  logic [SCAN_W-1:0]     valid_ext;
  logic [SEL_W-1:0]      scan_idx [NUM_REQS];
  logic                  win_found;
  logic [SEL_W-1:0]      win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  fire;
  logic                  pop;

  // ------------------------------------------------------------------
  // Output buffer state (2 entries)
  // ------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] data_mem [2];
  logic [SEL_W-1:0]      sel_mem  [2];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;
  logic [1:0]            count_next;
  logic                  full_reg;
  logic                  valid_reg;

  assign valid_ext = SCAN_W'(req_valid);

  // Slot visited at each scan offset: (ptr + offset), wrapped explicitly
  // at NUM_REQS rather than at a power of two.
  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_scan
    logic [SEL_W:0] raw;
    assign raw = {1'b0, ptr_reg} + (SEL_W+1)'(gi);
    assign scan_idx[gi] = (raw >= (SEL_W+1)'(NUM_REQS))
                        ? SEL_W'(raw - (SEL_W+1)'(NUM_REQS))
                        : raw[SEL_W-1:0];
  end

  // Pick the first valid slot starting at ptr. The scan runs from the
  // farthest offset back to offset 0, so the closest valid slot wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      if (valid_ext[scan_idx[k]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[k];
      end
    end
  end

  // Route the winner's payload into the buffer write port.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (win_idx == SEL_W'(i)) begin
        win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Only the winner may be ready. Readiness depends solely on registered
  // state (full flag) and reset, never on out_ready. A write into a full
  // buffer is therefore never offered, even while it is being drained.
  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_ready
    assign req_ready[gi] = win_found && (win_idx == SEL_W'(gi))
                           && !full_reg && !reset;
  end

  assign fire = win_found && !full_reg && !reset;
  assign pop  = valid_reg && out_ready;

  // Pointer moves to the slot after the winner, wrapping at NUM_REQS.
  assign ptr_next = (win_idx == SEL_W'(NUM_REQS - 1)) ? '0 : win_idx + SEL_W'(1);

  // Priority pointer register: advances only on a fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (fire) begin
      ptr_reg <= ptr_next;
    end
  end

  // Occupancy bookkeeping. A write and a read together leave the count
  // unchanged. A write into a full buffer cannot happen, because fire
  // already requires !full_reg.
  always_comb begin
    count_next = count_reg;
    case ({fire, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Buffer control registers. Reset flushes held entries; they are
  // dropped rather than delivered.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      full_reg   <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      if (fire) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == 2'd2);
      valid_reg <= (count_next != 2'd0);
    end
  end

  // Buffer storage. It has no reset: contents only matter while valid.
  always_ff @(posedge clk) begin
    if (fire) begin
      data_mem[wr_ptr_reg] <= win_data;
      sel_mem[wr_ptr_reg]  <= win_idx;
    end
  end

  // The head entry drives the unit directly from registers. This keeps
  // data and sel stable while the unit stalls.
  assign out_valid = valid_reg;
  assign out_data  = data_mem[rd_ptr_reg];
  assign out_sel   = sel_mem[rd_ptr_reg];

`ifdef VX_EXE_ARB_PERF_EN
  logic [31:0] stalls_reg;
  logic [31:0] conflicts_reg;
  logic        any_valid;
  logic        multi_valid;

  assign any_valid = |req_valid;
  // Clearing the lowest set bit leaves something only if 2+ bits were set.
  assign multi_valid = (req_valid & (req_valid - NUM_REQS'(1))) != '0;

  // Performance counters: stalls = requests pending with no fire;
  // conflicts = two or more slots competing. Both wrap modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stalls_reg    <= '0;
      conflicts_reg <= '0;
    end else begin
      if (any_valid && !fire) begin
        stalls_reg <= stalls_reg + 32'd1;
      end
      if (multi_valid) begin
        conflicts_reg <= conflicts_reg + 32'd1;
      end
    end
  end

  assign perf_stalls    = stalls_reg;
  assign perf_conflicts = conflicts_reg;
`else
  assign perf_stalls    = 32'd0;
  assign perf_conflicts = 32'd0;
`endif

endmodule

// File: tb/tb_vx_exe_issue_arb.sv
// tb_vx_exe_issue_arb
//   Drives a 4-slot instance through a table of round-robin / pointer-skip
//   vectors and hand-written backpressure, reset, and perf-counter sequences.
//   It then runs random traffic against a queue-based reference model.
//   A separate 3-slot instance covers the non-power-of-2 grant order.
module tb_vx_exe_issue_arb;

  localparam int DW = 64;

  logic clk;
  logic reset;

  // 4-slot instance
  logic [3:0]      req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]      req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_sel;
  logic            out_ready;
  logic [31:0]     perf_stalls;
  logic [31:0]     perf_conflicts;

  // 3-slot instance
  logic [2:0]      n3_valid;
  logic [3*DW-1:0] n3_data;
  logic [2:0]      n3_ready;
  logic            n3_ovalid;
  logic [DW-1:0]   n3_odata;
  logic [1:0]      n3_osel;
  logic            n3_oready;
  logic [31:0]     n3_stalls;
  logic [31:0]     n3_conflicts;

  vx_exe_issue_arb #(.NUM_REQS(4), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_sel        (out_sel),
    .out_ready      (out_ready),
    .perf_stalls    (perf_stalls),
    .perf_conflicts (perf_conflicts)
  );

  vx_exe_issue_arb #(.NUM_REQS(3), .DATA_WIDTH(DW)) dut3 (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (n3_valid),
    .req_data       (n3_data),
    .req_ready      (n3_ready),
    .out_valid      (n3_ovalid),
    .out_data       (n3_odata),
    .out_sel        (n3_osel),
    .out_ready      (n3_oready),
    .perf_stalls    (n3_stalls),
    .perf_conflicts (n3_conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    n3_valid  = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t tbl [11];

  // reference model state for the random phase
  typedef struct {
    logic [1:0]  sel;
    logic [63:0] data;
  } ent_t;

  ent_t        mq [$];
  int          mptr;
  int          m_stalls;
  int          m_conf;
  logic [3:0]  pend;
  logic [63:0] pdata [4];

  initial begin
    // Round-robin from reset, then a pointer skip and a drain.
    // Payload of slot i is 0x1000+i throughout.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[6]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd1};  // ptr=2 -> wraps to 0
    tbl[7]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd0};  // ptr=1 -> slot 3
    tbl[8]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3};  // ptr=0 -> slot 0
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    n3_valid  = '0;
    n3_data   = '0;
    n3_oready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_perf_stalls", 64'(perf_stalls), 64'd0);
    chk("rst_perf_conflicts", 64'(perf_conflicts), 64'd0);
    chk("rst_n3_out_valid", 64'(n3_ovalid), 64'd0);
    $display("reset: out_valid=%b req_ready=%b", out_valid, req_ready);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = 64'h1000 + 64'(i);
    for (int i = 0; i < 11; i++) begin
      logic [63:0] ed;
      req_valid = tbl[i].valid;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_rdy", i), 64'(req_ready), 64'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_ov", i), 64'(out_valid), 64'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) begin
        ed = 64'h1000 + 64'(tbl[i].exp_sel);
        chk($sformatf("tbl%0d_sel", i), 64'(out_sel), 64'(tbl[i].exp_sel));
        chk($sformatf("tbl%0d_data", i), out_data, ed);
      end
      $display("tbl %0d: valid=%b ready=%b out_valid=%b out_sel=%0d",
               i, req_valid, req_ready, out_valid, out_sel);
      @(negedge clk);
    end

    // ---------------- backpressure (ptr=1, empty) ----------------
    out_ready = 1'b0;
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 64'hA;
    #1;
    chk("bp0_rdy", 64'(req_ready), 64'b0100);
    chk("bp0_ov", 64'(out_valid), 64'd0);
    $display("bp 0: ready=%b out_valid=%b", req_ready, out_valid);
    @(negedge clk);
    req_data[2*DW +: DW] = 64'hB;
    #1;
    chk("bp1_rdy", 64'(req_ready), 64'b0100);
    chk("bp1_ov", 64'(out_valid), 64'd1);
    chk("bp1_data", out_data, 64'hA);
    $display("bp 1: ready=%b out_data=%0h", req_ready, out_data);
    @(negedge clk);
    req_data[2*DW +: DW] = 64'hC;
    for (int c = 2; c < 4; c++) begin
      #1;
      chk($sformatf("bp%0d_rdy", c), 64'(req_ready), 64'd0);
      chk($sformatf("bp%0d_data", c), out_data, 64'hA);
      $display("bp %0d: ready=%b out_data=%0h", c, req_ready, out_data);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp4_rdy", 64'(req_ready), 64'd0);
    chk("bp4_data", out_data, 64'hA);
    $display("bp 4: ready=%b out_data=%0h", req_ready, out_data);
    @(negedge clk);
    #1;
    chk("bp5_rdy", 64'(req_ready), 64'b0100);
    chk("bp5_data", out_data, 64'hB);
    $display("bp 5: ready=%b out_data=%0h", req_ready, out_data);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("bp6_data", out_data, 64'hC);
    chk("bp6_sel", 64'(out_sel), 64'd2);
    $display("bp 6: out_data=%0h", out_data);
    @(negedge clk);
    #1;
    chk("bp7_ov", 64'(out_valid), 64'd0);
    $display("bp 7: out_valid=%b", out_valid);

    // ---------------- reset mid-operation (ptr=3, empty) ----------------
    @(negedge clk);
    out_ready = 1'b0;
    req_data[0*DW +: DW] = 64'h55;
    req_data[1*DW +: DW] = 64'h77;
    req_valid = 4'b0001;
    #1;
    chk("rm0_rdy", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    chk("rm1_rdy", 64'(req_ready), 64'b0010);
    chk("rm1_data", out_data, 64'h55);
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("rm2_rdy_full", 64'(req_ready), 64'd0);
    chk("rm2_ov", 64'(out_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rm3_rdy_in_reset", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    req_data[0*DW +: DW] = 64'h66;
    #1;
    chk("rm4_ov_flushed", 64'(out_valid), 64'd0);
    chk("rm4_rdy_ptr0", 64'(req_ready), 64'b0001);
    @(negedge clk);
    #1;
    chk("rm5_ov", 64'(out_valid), 64'd1);
    chk("rm5_data", out_data, 64'h66);
    chk("rm5_sel", 64'(out_sel), 64'd0);
    chk("rm5_rdy", 64'(req_ready), 64'b0010);
    $display("rm: out_valid=%b out_data=%0h ready=%b", out_valid, out_data, req_ready);

    // ---------------- non-power-of-2 (NUM_REQS=3) ----------------
    do_reset();
    n3_valid  = 3'b111;
    n3_oready = 1'b1;
    for (int i = 0; i < 3; i++) n3_data[i*DW +: DW] = 64'h300 + 64'(i);
    for (int c = 0; c < 7; c++) begin
      #1;
      chk($sformatf("n3_%0d_rdy", c), 64'(n3_ready), 64'(1 << (c % 3)));
      if (c > 0) begin
        chk($sformatf("n3_%0d_sel", c), 64'(n3_osel), 64'((c - 1) % 3));
        chk($sformatf("n3_%0d_data", c), n3_odata, 64'h300 + 64'((c - 1) % 3));
      end
      $display("n3 %0d: ready=%b out_sel=%0d", c, n3_ready, n3_osel);
      @(negedge clk);
    end
    n3_valid = '0;

    // ---------------- perf counters ----------------
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 4'b0011;
    out_ready = 1'b0;
    #1;
    chk("pf_rdy_in_reset", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
`ifdef VX_EXE_ARB_PERF_EN
    chk("pf_conflicts", 64'(perf_conflicts), 64'd10);
    chk("pf_stalls", 64'(perf_stalls), 64'd8);
`else
    chk("pf_conflicts", 64'(perf_conflicts), 64'd0);
    chk("pf_stalls", 64'(perf_stalls), 64'd0);
`endif
    $display("perf: stalls=%0d conflicts=%0d", perf_stalls, perf_conflicts);

    // ---------------- random traffic vs. reference model ----------------
    do_reset();
    mq.delete();
    mptr     = 0;
    m_stalls = 0;
    m_conf   = 0;
    pend     = '0;
    for (int i = 0; i < 4; i++) pdata[i] = '0;
    for (int c = 0; c < 300; c++) begin
      logic [3:0] exp_rdy;
      int         g;
      int         nvalid;
      for (int s = 0; s < 4; s++) begin
        if (!pend[s] && $urandom_range(0, 2) == 0) begin
          pend[s]  = 1'b1;
          pdata[s] = {$urandom, $urandom};
        end
        req_data[s*DW +: DW] = pdata[s];
      end
      req_valid = pend;
      out_ready = ($urandom_range(0, 3) != 0);

      // expected winner: first pending slot from mptr, if buffer not full
      exp_rdy = '0;
      g = -1;
      if (mq.size() < 2) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && pend[(mptr + k) % 4]) g = (mptr + k) % 4;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;

      #1;
      chk($sformatf("rnd%0d_rdy", c), 64'(req_ready), 64'(exp_rdy));
      chk($sformatf("rnd%0d_ov", c), 64'(out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk($sformatf("rnd%0d_sel", c), 64'(out_sel), 64'(mq[0].sel));
        chk($sformatf("rnd%0d_data", c), out_data, mq[0].data);
      end
`ifdef VX_EXE_ARB_PERF_EN
      chk($sformatf("rnd%0d_stalls", c), 64'(perf_stalls), 64'(m_stalls));
      chk($sformatf("rnd%0d_conf", c), 64'(perf_conflicts), 64'(m_conf));
`else
      chk($sformatf("rnd%0d_stalls", c), 64'(perf_stalls), 64'd0);
      chk($sformatf("rnd%0d_conf", c), 64'(perf_conflicts), 64'd0);
`endif
      $display("rnd %0d: valid=%b ready=%b out_valid=%b out_sel=%0d",
               c, req_valid, req_ready, out_valid, out_sel);

      // advance the model across the coming clock edge
      nvalid = 0;
      for (int s = 0; s < 4; s++) if (pend[s]) nvalid++;
      if (nvalid > 0 && g < 0) m_stalls++;
      if (nvalid >= 2) m_conf++;
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (g >= 0) begin
        mq.push_back('{sel: 2'(g), data: pdata[g]});
        mptr    = (g + 1) % 4;
        pend[g] = 1'b0;
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
